// File: rtl/tt_fitness_evaluator_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : tt_fitness_evaluator_if                                           |
// | Brief   : Bundles the controller, DUT and truth-table ROM signals.          |
// | Rev     : 1.0  initial release                                              |
// +-----------------------------------------------------------------------------+
interface tt_fitness_evaluator_if #(
    parameter int N_IN  = 10,
    parameter int N_OUT = 8
);
    localparam int c_fit_w = N_IN + $clog2(N_OUT) + 1;
    localparam int c_bad_w = N_IN + 1;

    logic                start;
    logic                abort;
    logic [N_IN-1:0]     pi;
    logic [N_OUT-1:0]    po;
    logic [N_IN-1:0]     exp_addr;
    logic [N_OUT-1:0]    exp_data;
    logic                busy;
    logic                done;
    logic [c_fit_w-1:0]  fitness;
    logic [c_bad_w-1:0]  bad_rows;

    // The evaluator drives the vector bus and reports results.
    modport master (
        input  start, abort, po, exp_data,
        output pi, exp_addr, busy, done, fitness, bad_rows
    );

    modport slave (
        output start, abort, po, exp_data,
        input  pi, exp_addr, busy, done, fitness, bad_rows
    );
endinterface
`default_nettype wire

// File: rtl/tt_fitness_evaluator.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : tt_fitness_evaluator                                              |
// | Brief   : Sweeps all input vectors of a benchmark netlist and counts the    |
// |           output bits that match the truth-table ROM (CGP fitness).        |
// | Rev     : 1.0  initial release                                              |
// +-----------------------------------------------------------------------------+
module tt_fitness_evaluator #(
    parameter int N_IN  = 10,
    parameter int N_OUT = 8,
    parameter int LAT   = 0
) (
    input wire clk,
    input wire rst_n,
    tt_fitness_evaluator_if.master bus
);
    localparam int c_fit_w = N_IN + $clog2(N_OUT) + 1;
    localparam int c_bad_w = N_IN + 1;
    localparam int c_pop_w = $clog2(N_OUT) + 1;
    localparam int c_dw    = $clog2(LAT + 1) + 1;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam logic [c_dw-1:0] c_drain_last = c_dw'(LAT);
    localparam logic [LAT:0]    c_vld_one    = (LAT + 1)'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [N_IN:0]      r_cnt;
    logic [c_dw-1:0]    r_dcnt;
    logic [LAT:0]       r_vld;
    logic [N_OUT-1:0]   r_po;
    logic [N_OUT-1:0]   w_exp;
    logic [N_OUT-1:0]   w_match;
    logic [c_pop_w-1:0] w_pop;
    logic               w_row_bad;
    logic [c_fit_w-1:0] r_fit;
    logic [c_bad_w-1:0] r_bad;
    logic               w_accept;
    logic               w_abort;
    logic               w_issue;

    // Counter MSB marks "all vectors issued"; the extra RUN clock it costs
    // lines the done pulse up with the final accumulator update.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_abort   = 1'b0;
        w_issue   = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (bus.start) begin
                    w_next   = c_st_run;
                    w_accept = 1'b1;
                end
            end
            c_st_run: begin
                w_issue = ~r_cnt[N_IN];
                if (bus.abort) begin
                    w_next  = c_st_idle;
                    w_abort = 1'b1;
                end else if (r_cnt[N_IN]) begin
                    w_next = c_st_drain;
                end
            end
            c_st_drain: begin
                if (bus.abort) begin
                    w_next  = c_st_idle;
                    w_abort = 1'b1;
                end else if (r_dcnt == c_drain_last) begin
                    w_next = c_st_done;
                end
            end
            default: w_next = c_st_idle;
        endcase
    end

    generate
        if (LAT > 0) begin : g_exp_dly
            logic [N_OUT-1:0] r_exp_pipe [LAT];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < LAT; i++) r_exp_pipe[i] <= '0;
                end else begin
                    r_exp_pipe[0] <= bus.exp_data;
                    for (int i = 1; i < LAT; i++) r_exp_pipe[i] <= r_exp_pipe[i-1];
                end
            end
            assign w_exp = r_exp_pipe[LAT-1];
        end else begin : g_exp_direct
            assign w_exp = bus.exp_data;
        end
    endgenerate

    always_comb begin
        w_match   = ~(r_po ^ w_exp);
        w_row_bad = |(r_po ^ w_exp);
        w_pop     = '0;
        for (int i = 0; i < N_OUT; i++) w_pop = w_pop + c_pop_w'(w_match[i]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_dcnt  <= '0;
            r_vld   <= '0;
            r_po    <= '0;
            r_fit   <= '0;
            r_bad   <= '0;
        end else begin
            r_state <= w_next;
            r_po    <= bus.po;
            if (w_accept || w_abort) begin
                r_cnt  <= '0;
                r_dcnt <= '0;
                r_vld  <= '0;
                r_fit  <= '0;
                r_bad  <= '0;
            end else begin
                r_vld <= (r_vld << 1) | (w_issue ? c_vld_one : '0);
                if (w_issue) r_cnt <= r_cnt + 1'b1;
                if (r_state == c_st_drain) r_dcnt <= r_dcnt + 1'b1;
                if (r_vld[LAT]) begin
                    r_fit <= r_fit + c_fit_w'(w_pop);
                    r_bad <= r_bad + c_bad_w'(w_row_bad);
                end
            end
        end
    end

    assign bus.pi       = r_cnt[N_IN-1:0];
    assign bus.exp_addr = r_cnt[N_IN-1:0];
    assign bus.busy     = (r_state == c_st_run) || (r_state == c_st_drain);
    assign bus.done     = (r_state == c_st_done);
    assign bus.fitness  = r_fit;
    assign bus.bad_rows = r_bad;
endmodule
`default_nettype wire

// File: tb/tb_tt_fitness_evaluator.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : tb_tt_fitness_evaluator                                           |
// | Brief   : Self-checking bench: 10-in/8-out ALU netlist, truth-table ROM,    |
// |           LAT=0 and LAT=2 evaluator instances.                              |
// | Rev     : 1.0  initial release                                              |
// +-----------------------------------------------------------------------------+
module tb_tt_fitness_evaluator;
    localparam int N_IN  = 10;
    localparam int N_OUT = 8;
    localparam int NV    = 1 << N_IN;

    logic clk = 1'b0;
    logic rst_n;
    int   n_err = 0;
    int   n_checks = 0;

    always #5 clk = ~clk;

    tt_fitness_evaluator_if #(.N_IN(N_IN), .N_OUT(N_OUT)) if0 ();
    tt_fitness_evaluator_if #(.N_IN(N_IN), .N_OUT(N_OUT)) if2 ();

    tt_fitness_evaluator #(.N_IN(N_IN), .N_OUT(N_OUT), .LAT(0)) u_eval0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.master));
    tt_fitness_evaluator #(.N_IN(N_IN), .N_OUT(N_OUT), .LAT(2)) u_eval2 (
        .clk(clk), .rst_n(rst_n), .bus(if2.master));

    // Golden benchmark: op = v[9:8], a = v[3:0], b = v[7:4]
    function automatic logic [7:0] golden(input logic [9:0] v);
        logic [7:0] a, b;
        a = {4'd0, v[3:0]};
        b = {4'd0, v[7:4]};
        case (v[9:8])
            2'd0:    golden = a + b;
            2'd1:    golden = a - b;
            2'd2:    golden = {v[3:0] ^ v[7:4], v[3:0] & v[7:4]};
            default: golden = a * b;
        endcase
    endfunction

    logic [7:0] rom0 [NV];
    logic [7:0] rom2 [NV];
    logic [7:0] d1, d2;

    always @(posedge clk) if0.exp_data <= rom0[if0.exp_addr];
    always @(posedge clk) if2.exp_data <= rom2[if2.exp_addr];
    always_comb if0.po = golden(if0.pi);
    always @(posedge clk) begin
        d1 <= golden(if2.pi);
        d2 <= d1;
    end
    assign if2.po = d2;

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic flip(input int sel, input int row, input int b);
        if (sel == 0) rom0[row][b] = ~rom0[row][b];
        else          rom2[row][b] = ~rom2[row][b];
    endtask

    task automatic load_rom(input int sel, input int inv, input int r0, input int b0,
                            input int r1, input int b1);
        logic [7:0] w;
        for (int v = 0; v < NV; v++) begin
            w = golden(v[9:0]);
            if (inv != 0) w = ~w;
            if (sel == 0) rom0[v] = w;
            else          rom2[v] = w;
        end
        if (r0 >= 0) flip(sel, r0, b0);
        if (r1 >= 0) flip(sel, r1, b1);
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) if0.start = v;
        else          if2.start = v;
    endtask

    function automatic logic get_done(input int sel);
        return (sel == 0) ? if0.done : if2.done;
    endfunction
    function automatic logic get_busy(input int sel);
        return (sel == 0) ? if0.busy : if2.busy;
    endfunction
    function automatic int get_fit(input int sel);
        return (sel == 0) ? int'(if0.fitness) : int'(if2.fitness);
    endfunction
    function automatic int get_bad(input int sel);
        return (sel == 0) ? int'(if0.bad_rows) : int'(if2.bad_rows);
    endfunction

    // Starts a sweep; lat is the clock count from the start-sampling edge to done.
    task automatic run_sweep(input int sel, output int fit, output int bad,
                             output int lat, output int pulse_ok, output int busy1);
        @(negedge clk);
        set_start(sel, 1'b1);
        @(posedge clk);
        #1;
        set_start(sel, 1'b0);
        lat = -1; fit = -1; bad = -1; pulse_ok = 0; busy1 = 0;
        for (int k = 1; k <= 3000; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) busy1 = int'(get_busy(sel));
            if (get_done(sel)) begin
                lat = k;
                fit = get_fit(sel);
                bad = get_bad(sel);
                break;
            end
        end
        @(posedge clk);
        #1;
        pulse_ok = int'(!get_done(sel) && !get_busy(sel) && get_fit(sel) == fit);
    endtask

    typedef struct {
        string name;
        int    sel;
        int    inv;
        int    r0, b0, r1, b1;
        int    fit, bad, lat;
    } vec_t;

    vec_t tbl [5];
    int   fit, bad, lat, pok, busy1, cnt, ef, eb, sel, nflip, found;
    logic [7:0] diff;

    initial begin
        tbl[0] = '{"t1_golden",  0, 0, -1, 0, -1, 0, 8192,    0, 1026};
        tbl[1] = '{"t2_inverse", 0, 1, -1, 0, -1, 0,    0, 1024, 1026};
        tbl[2] = '{"t3_flip1",   0, 0,  5, 3, -1, 0, 8191,    1, 1026};
        tbl[3] = '{"t3_flip2",   0, 0,  5, 3, 1023, 7, 8190,  2, 1026};
        tbl[4] = '{"t4_lat2",    1, 0, -1, 0, -1, 0, 8192,    0, 1028};

        rst_n = 1'b0;
        if0.start = 1'b0; if0.abort = 1'b0;
        if2.start = 1'b0; if2.abort = 1'b0;
        load_rom(0, 0, -1, 0, -1, 0);
        load_rom(1, 0, -1, 0, -1, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_pi",      if0.pi, 0);
        check("rst_fitness", if0.fitness, 0);
        check("rst_bad",     if0.bad_rows, 0);
        check("rst_busy",    {if0.busy, if2.busy}, 0);
        check("rst_done",    {if0.done, if2.done}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            load_rom(tbl[i].sel, tbl[i].inv, tbl[i].r0, tbl[i].b0, tbl[i].r1, tbl[i].b1);
            run_sweep(tbl[i].sel, fit, bad, lat, pok, busy1);
            check({tbl[i].name, "_fit"},   fit, tbl[i].fit);
            check({tbl[i].name, "_bad"},   bad, tbl[i].bad);
            check({tbl[i].name, "_lat"},   lat, tbl[i].lat);
            check({tbl[i].name, "_busy"},  busy1, 1);
            check({tbl[i].name, "_pulse"}, pok, 1);
        end

        // Random ROM corruption against a row-by-row model
        for (int it = 0; it < 4; it++) begin
            sel   = int'($urandom_range(0, 1));
            nflip = int'($urandom_range(0, 40));
            load_rom(sel, 0, -1, 0, -1, 0);
            for (int f = 0; f < nflip; f++)
                flip(sel, int'($urandom_range(0, NV - 1)), int'($urandom_range(0, 7)));
            ef = 0; eb = 0;
            for (int v = 0; v < NV; v++) begin
                diff = golden(v[9:0]) ^ ((sel == 0) ? rom0[v] : rom2[v]);
                ef += 8 - $countones(diff);
                if (diff != 0) eb++;
            end
            run_sweep(sel, fit, bad, lat, pok, busy1);
            check("rand_fit", fit, ef);
            check("rand_bad", bad, eb);
            check("rand_lat", lat, (sel == 0) ? 1026 : 1028);
        end

        // T5: abort at vector 300
        load_rom(0, 0, -1, 0, -1, 0);
        @(negedge clk); if0.start = 1'b1;
        @(posedge clk); #1; if0.start = 1'b0;
        found = 0;
        for (int k = 0; k < 2000; k++) begin
            if (if0.pi == 10'd300) begin found = 1; break; end
            @(posedge clk); #1;
        end
        check("t5_reach300", found, 1);
        check("t5_fit_pre", if0.fitness, 299 * 8);
        @(negedge clk); if0.abort = 1'b1;
        @(posedge clk); #1; if0.abort = 1'b0;
        check("t5_busy", if0.busy, 0);
        check("t5_fit",  if0.fitness, 0);
        check("t5_bad",  if0.bad_rows, 0);
        check("t5_pi",   if0.pi, 0);
        cnt = 0;
        for (int k = 0; k < 1100; k++) begin
            @(posedge clk); #1;
            if (if0.done || if0.busy) cnt++;
        end
        check("t5_no_done", cnt, 0);
        run_sweep(0, fit, bad, lat, pok, busy1);
        check("t5_rerun_fit", fit, 8192);
        check("t5_rerun_lat", lat, 1026);

        // T6: start re-pulsed mid-run is ignored
        @(negedge clk); if0.start = 1'b1;
        @(posedge clk); #1; if0.start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 3000; k++) begin
            @(posedge clk); #1;
            if0.start = (k == 500);
            if (if0.done) begin lat = k; fit = int'(if0.fitness); break; end
        end
        if0.start = 1'b0;
        check("t6_repulse_lat", lat, 1026);
        check("t6_repulse_fit", fit, 8192);

        // T6: reset mid-run
        @(negedge clk); if0.start = 1'b1;
        @(posedge clk); #1; if0.start = 1'b0;
        repeat (400) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        check("t6_rst_pi",   if0.pi, 0);
        check("t6_rst_fit",  if0.fitness, 0);
        check("t6_rst_bad",  if0.bad_rows, 0);
        check("t6_rst_busy", if0.busy, 0);
        check("t6_rst_done", if0.done, 0);
        @(negedge clk); rst_n = 1'b1;
        run_sweep(0, fit, bad, lat, pok, busy1);
        check("t6_rerun_fit", fit, 8192);
        check("t6_rerun_bad", bad, 0);
        check("t6_rerun_lat", lat, 1026);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
